// File: rtl/exc_ctrl_pkg.sv
// Shared exception-controller definitions: codes, CP0 addresses, bit positions.
package exc_ctrl_pkg;

    localparam int XLEN      = 32;
    localparam int INT_LINES = 6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } exc_state_t;

    // Exception codes written to CP0
    localparam logic [XLEN-1:0] EXC_NONE    = 32'h0;
    localparam logic [XLEN-1:0] EXC_INT     = 32'h1;
    localparam logic [XLEN-1:0] EXC_SYSCALL = 32'h8;
    localparam logic [XLEN-1:0] EXC_RI      = 32'ha;
    localparam logic [XLEN-1:0] EXC_TRAP    = 32'hd;
    localparam logic [XLEN-1:0] EXC_OV      = 32'hc;
    localparam logic [XLEN-1:0] EXC_ERET    = 32'he;

    // Bit positions in the MEM-stage exception flag vector
    localparam int EXC_BIT_SYSCALL = 8;
    localparam int EXC_BIT_RI      = 9;
    localparam int EXC_BIT_TRAP    = 10;
    localparam int EXC_BIT_OV      = 11;
    localparam int EXC_BIT_ERET    = 12;

    // CP0 register addresses
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // Status / cause field positions
    localparam int STATUS_IE       = 0;
    localparam int STATUS_EXL      = 1;
    localparam int STATUS_IM_LSB   = 8;
    localparam int STATUS_IM_MSB   = 15;
    localparam int CAUSE_IP_SW_LSB = 8;
    localparam int CAUSE_IP_SW_MSB = 9;

    // Stall vectors, bit0 = PC
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    // WB-stage forwarding of a CP0 register that is being written this cycle
    function automatic logic [XLEN-1:0] cp0_bypass(input logic we, input logic [4:0] waddr,
                                                   input logic [XLEN-1:0] wdata,
                                                   input logic [4:0] addr,
                                                   input logic [XLEN-1:0] cur);
        return (we && (waddr == addr)) ? wdata : cur;
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Pipeline/CP0 <-> exception controller signal bundle.
interface exc_ctrl_if
    import exc_ctrl_pkg::*;
    ;
    logic [INT_LINES-1:0] int_i;
    logic                 timer_int_i;
    logic [XLEN-1:0]      mem_exc_i;
    logic [XLEN-1:0]      mem_pc_i;
    logic                 mem_dslot_i;
    logic [XLEN-1:0]      status_i;
    logic [XLEN-1:0]      cause_i;
    logic [XLEN-1:0]      epc_i;
    logic                 wb_cp0_we_i;
    logic [4:0]           wb_cp0_waddr_i;
    logic [XLEN-1:0]      wb_cp0_wdata_i;
    logic                 stallreq_id_i;
    logic                 stallreq_ex_i;
    logic                 stallreq_mem_i;
    logic [XLEN-1:0]      excepttype_o;
    logic [XLEN-1:0]      pc_o;
    logic                 dslot_o;
    logic [INT_LINES-1:0] int_o;
    logic                 flush_o;
    logic [XLEN-1:0]      new_pc_o;
    logic [5:0]           stall_o;

    // Exception controller side
    modport slave (
        input  int_i, timer_int_i, mem_exc_i, mem_pc_i, mem_dslot_i,
               status_i, cause_i, epc_i, wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i,
               stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output excepttype_o, pc_o, dslot_o, int_o, flush_o, new_pc_o, stall_o
    );

    // Pipeline / CP0 side
    modport master (
        output int_i, timer_int_i, mem_exc_i, mem_pc_i, mem_dslot_i,
               status_i, cause_i, epc_i, wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i,
               stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  excepttype_o, pc_o, dslot_o, int_o, flush_o, new_pc_o, stall_o
    );
endinterface

// File: rtl/exc_ctrl_int_sync.sv
// Multi-flop synchronizer for asynchronous interrupt lines.
module int_sync #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);
    logic [DEPTH-1:0][WIDTH-1:0] r_sync;

    // Shift chain; reset clears every stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_async;
            for (int k = 1; k < DEPTH; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    assign o_sync = r_sync[DEPTH-1];
endmodule

// File: rtl/exc_ctrl.sv
// Exception controller: prioritizes MEM-stage exceptions and interrupts,
// issues flush/redirect, arbitrates stalls, and holds off re-entry after a flush.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0040,
    parameter int          HOLD_CYCLES = 2,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    exc_ctrl_if.slave  bus
);
    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);

    exc_state_t           r_state;
    logic [3:0]           r_cnt;
    logic [INT_LINES-1:0] w_int_sync;
    logic [INT_LINES-1:0] w_int;
    logic [XLEN-1:0]      w_status, w_cause, w_epc;
    logic [7:0]           w_ip;
    logic                 w_int_pend;
    logic [XLEN-1:0]      w_code;
    logic                 w_accept;
    logic                 w_unused;

    int_sync #(.WIDTH(INT_LINES), .DEPTH(SYNC_STAGES)) u_int_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.int_i),
        .o_sync  (w_int_sync)
    );

    // Timer line joins IP7 after synchronization; everything held low in reset
    assign w_int = rst ? '0 : (w_int_sync | {bus.timer_int_i, {(INT_LINES-1){1'b0}}});

    assign w_status = cp0_bypass(bus.wb_cp0_we_i, bus.wb_cp0_waddr_i, bus.wb_cp0_wdata_i,
                                 CP0_STATUS, bus.status_i);
    assign w_cause  = cp0_bypass(bus.wb_cp0_we_i, bus.wb_cp0_waddr_i, bus.wb_cp0_wdata_i,
                                 CP0_CAUSE, bus.cause_i);
    assign w_epc    = cp0_bypass(bus.wb_cp0_we_i, bus.wb_cp0_waddr_i, bus.wb_cp0_wdata_i,
                                 CP0_EPC, bus.epc_i);

    // Hardware IP[7:2] come from the synchronized lines, software IP[1:0] from cause
    assign w_ip       = {w_int, w_cause[CAUSE_IP_SW_MSB:CAUSE_IP_SW_LSB]};
    assign w_int_pend = w_status[STATUS_IE] & ~w_status[STATUS_EXL]
                      & (|(w_ip & w_status[STATUS_IM_MSB:STATUS_IM_LSB]));

    assign w_unused = ^{w_status[XLEN-1:STATUS_IM_MSB+1], w_status[STATUS_IM_LSB-1:STATUS_EXL+1],
                        w_cause[XLEN-1:CAUSE_IP_SW_MSB+1], w_cause[CAUSE_IP_SW_LSB-1:0],
                        bus.mem_exc_i[XLEN-1:EXC_BIT_ERET+1], bus.mem_exc_i[EXC_BIT_SYSCALL-1:0]};

    // Fixed-priority encoder, interrupt highest
    always_comb begin
        w_code = EXC_NONE;
        if (w_int_pend)                        w_code = EXC_INT;
        else if (bus.mem_exc_i[EXC_BIT_SYSCALL]) w_code = EXC_SYSCALL;
        else if (bus.mem_exc_i[EXC_BIT_RI])      w_code = EXC_RI;
        else if (bus.mem_exc_i[EXC_BIT_TRAP])    w_code = EXC_TRAP;
        else if (bus.mem_exc_i[EXC_BIT_OV])      w_code = EXC_OV;
        else if (bus.mem_exc_i[EXC_BIT_ERET])    w_code = EXC_ERET;
    end

    // Bubbles (pc 0) and the post-flush window never take an exception
    assign w_accept = !rst && (r_state == ST_IDLE) && (bus.mem_pc_i != '0) && (w_code != EXC_NONE);

    // Same-cycle flush/redirect and stall arbitration; a flush wins over stalls
    always_comb begin
        bus.excepttype_o = w_accept ? w_code : EXC_NONE;
        bus.flush_o      = w_accept;
        bus.new_pc_o     = '0;
        if (w_accept) bus.new_pc_o = (w_code == EXC_ERET) ? w_epc : EXC_VECTOR;
        bus.stall_o = STALL_NONE;
        if (!rst && !w_accept) begin
            if (bus.stallreq_mem_i)     bus.stall_o = STALL_MEM;
            else if (bus.stallreq_ex_i) bus.stall_o = STALL_EX;
            else if (bus.stallreq_id_i) bus.stall_o = STALL_ID;
        end
        bus.pc_o    = bus.mem_pc_i;
        bus.dslot_o = bus.mem_dslot_i;
        bus.int_o   = w_int;
    end

    // IDLE/HOLD sequencing with a down-counting hold window
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_state <= ST_HOLD;
                    r_cnt   <= HOLD_INIT;
                end
                ST_HOLD: if (r_cnt == '0) r_state <= ST_IDLE;
                         else             r_cnt   <= r_cnt - 4'd1;
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// Directed + randomized bench for exc_ctrl against a behavioural model.
module tb_exc_ctrl;
    localparam int          HOLD = 2;
    localparam int          SYNC = 2;
    localparam logic [31:0] VEC  = 32'h0000_0040;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exc_ctrl_if bus();

    exc_ctrl #(.EXC_VECTOR(VEC), .HOLD_CYCLES(HOLD), .SYNC_STAGES(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Model state: cycles left in the post-flush window, and int_i history since reset
    int         hold_left = 0;
    logic [5:0] seen[$];

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] eff(input logic [4:0] a, input logic [31:0] cur);
        return (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == a) ? bus.wb_cp0_wdata_i : cur;
    endfunction

    function automatic logic [5:0] m_int_o();
        logic [5:0] d;
        if (rst) return 6'h0;
        d = (seen.size() >= SYNC) ? seen[seen.size()-SYNC] : 6'h0;
        return d | (bus.timer_int_i ? 6'h20 : 6'h0);
    endfunction

    function automatic logic [31:0] m_code();
        logic [31:0] st, ca, e;
        logic [7:0]  ip, im;
        if (rst || hold_left > 0 || bus.mem_pc_i == 32'h0) return 32'h0;
        st = eff(5'd12, bus.status_i);
        ca = eff(5'd13, bus.cause_i);
        ip = 8'((ca >> 8) & 32'h3) | 8'({2'b00, m_int_o()} << 2);
        im = 8'(st >> 8);
        if (st[0] && !st[1] && (ip & im) != 8'h0) return 32'h1;
        e = bus.mem_exc_i;
        if (e[8])  return 32'h8;
        if (e[9])  return 32'ha;
        if (e[10]) return 32'hd;
        if (e[11]) return 32'hc;
        if (e[12]) return 32'he;
        return 32'h0;
    endfunction

    // Compare every output against the model, a little after the inputs settle
    task automatic check_all();
        logic [31:0] c, npc;
        logic [5:0]  stl;
        #1;
        c   = m_code();
        npc = (c == 32'h0) ? 32'h0 : (c == 32'he) ? eff(5'd14, bus.epc_i) : VEC;
        stl = 6'h0;
        if (!rst && c == 32'h0)
            stl = bus.stallreq_mem_i ? 6'h1f : bus.stallreq_ex_i ? 6'h0f : bus.stallreq_id_i ? 6'h07 : 6'h0;
        cmp("excepttype", bus.excepttype_o, c);
        cmp("flush", 32'(bus.flush_o), 32'(c != 32'h0));
        cmp("new_pc", bus.new_pc_o, npc);
        cmp("stall", 32'(bus.stall_o), 32'(stl));
        cmp("int_o", 32'(bus.int_o), 32'(m_int_o()));
        cmp("pc_o", bus.pc_o, bus.mem_pc_i);
        cmp("dslot", 32'(bus.dslot_o), 32'(bus.mem_dslot_i));
    endtask

    // Advance one clock and update the model with what the edge saw
    task automatic tick();
        logic       acc, r;
        logic [5:0] iv;
        acc = (m_code() != 32'h0);
        r   = rst;
        iv  = bus.int_i;
        @(posedge clk);
        if (r) begin
            hold_left = 0;
            seen.delete();
        end else begin
            if (acc) hold_left = HOLD;
            else if (hold_left > 0) hold_left--;
            seen.push_back(iv);
            if (seen.size() > SYNC) void'(seen.pop_front());
        end
        #1;
    endtask

    task automatic quiet();
        bus.int_i = '0; bus.timer_int_i = 0; bus.mem_exc_i = '0; bus.mem_pc_i = '0;
        bus.mem_dslot_i = 0; bus.status_i = '0; bus.cause_i = '0; bus.epc_i = '0;
        bus.wb_cp0_we_i = 0; bus.wb_cp0_waddr_i = '0; bus.wb_cp0_wdata_i = '0;
        bus.stallreq_id_i = 0; bus.stallreq_ex_i = 0; bus.stallreq_mem_i = 0;
    endtask

    initial begin
        quiet();
        // Reset: outputs forced low even with live requests on the inputs
        rst = 1; tick(); tick();
        bus.mem_pc_i = 32'h100; bus.mem_exc_i = 32'h100; bus.stallreq_mem_i = 1; bus.timer_int_i = 1;
        check_all();
        cmp("rst_flush", 32'(bus.flush_o), 32'h0);
        cmp("rst_int_o", 32'(bus.int_o), 32'h0);
        quiet();
        rst = 0; tick();

        // Syscall, then overflow during the hold window is ignored
        bus.mem_pc_i = 32'h100; bus.mem_exc_i = 32'h100; bus.mem_dslot_i = 1;
        check_all();
        cmp("sys_code", bus.excepttype_o, 32'h8);
        cmp("sys_npc", bus.new_pc_o, 32'h40);
        tick(); bus.mem_exc_i = 32'h800; bus.mem_dslot_i = 0;
        check_all(); cmp("hold1_flush", 32'(bus.flush_o), 32'h0);
        tick(); check_all(); cmp("hold2_code", bus.excepttype_o, 32'h0);
        tick(); check_all(); cmp("ov_after_hold", bus.excepttype_o, 32'hc);
        bus.mem_exc_i = '0; tick(); tick(); tick();

        // ERET with epc forwarded from WB
        bus.mem_exc_i = 32'h1000; bus.epc_i = 32'h300;
        bus.wb_cp0_we_i = 1; bus.wb_cp0_waddr_i = 5'd14; bus.wb_cp0_wdata_i = 32'h200;
        check_all();
        cmp("eret_npc", bus.new_pc_o, 32'h200);
        cmp("eret_code", bus.excepttype_o, 32'he);
        tick(); quiet(); bus.mem_pc_i = 32'h104; tick(); tick();

        // Stall arbitration, and a flush overriding stalls
        bus.stallreq_ex_i = 1; bus.stallreq_mem_i = 1;
        check_all(); cmp("stall_mem", 32'(bus.stall_o), 32'h1f);
        bus.mem_exc_i = 32'h100;
        check_all();
        cmp("stall_flush", 32'(bus.stall_o), 32'h0);
        cmp("flush_over_stall", 32'(bus.flush_o), 32'h1);
        tick(); bus.stallreq_ex_i = 0; bus.stallreq_mem_i = 0; bus.stallreq_id_i = 1;
        check_all(); cmp("stall_id", 32'(bus.stall_o), 32'h07);
        tick(); bus.stallreq_id_i = 0; bus.stallreq_ex_i = 1;
        check_all(); cmp("stall_ex", 32'(bus.stall_o), 32'h0f);
        tick(); quiet(); tick();

        // Interrupt: deferred through sync latency and bubbles, beats overflow
        bus.status_i = 32'h0000_0401; bus.int_i = 6'h01;
        for (int k = 0; k <= SYNC; k++) begin
            check_all(); cmp("int_wait", bus.excepttype_o, 32'h0); tick();
        end
        bus.mem_pc_i = 32'h104; bus.mem_exc_i = 32'h800;
        check_all(); cmp("int_taken", bus.excepttype_o, 32'h1);
        tick(); bus.mem_exc_i = '0; bus.status_i = 32'h0000_0403;
        check_all(); tick(); check_all(); tick();
        check_all(); cmp("int_exl", bus.excepttype_o, 32'h0);
        quiet(); tick();

        // Reset mid-hold returns to IDLE immediately
        bus.mem_pc_i = 32'h108; bus.mem_exc_i = 32'h100;
        check_all(); tick();
        rst = 1; check_all(); tick();
        rst = 0; check_all(); cmp("sys_after_rst", bus.excepttype_o, 32'h8);
        tick(); quiet(); tick(); tick();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] e;
            e = '0;
            for (int b = 8; b <= 12; b++) if ($urandom_range(0, 5) == 0) e[b] = 1'b1;
            rst = ($urandom_range(0, 60) == 0);
            bus.mem_exc_i      = e;
            bus.mem_pc_i       = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & 32'hffff_fffc);
            bus.mem_dslot_i    = 1'($urandom);
            if ($urandom_range(0, 7) == 0) bus.int_i = 6'($urandom);
            bus.timer_int_i    = ($urandom_range(0, 15) == 0);
            bus.status_i       = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
            bus.cause_i        = {16'h0, 6'h0, 2'($urandom), 8'h0};
            bus.epc_i          = $urandom;
            bus.wb_cp0_we_i    = 1'($urandom);
            bus.wb_cp0_waddr_i = 5'($urandom_range(11, 15));
            bus.wb_cp0_wdata_i = ($urandom_range(0, 1) == 0) ? {16'h0, 8'($urandom), 6'h0, 2'($urandom)}
                                                              : $urandom;
            bus.stallreq_id_i  = 1'($urandom);
            bus.stallreq_ex_i  = 1'($urandom);
            bus.stallreq_mem_i = 1'($urandom);
            check_all();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h0000_0040; handler entry PC for all non-ERET exceptions.
REQ-002 Parameter HOLD_CYCLES, default 2; post-flush window length in cycles, range 1..15.
REQ-003 Parameter SYNC_STAGES, default 2; synchronizer depth on int_i.
REQ-004 Reset is rst, synchronous, active-high; clock is clk.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 int_i  in  6  asynchronous external interrupt lines.
REQ-008 timer_int_i  in  1  CP0 timer interrupt, already synchronous; ORed into line 5.
REQ-009 mem_exc_i  in  32  MEM-stage exception flag vector: bit8 syscall, bit9 RI, bit10 trap, bit11 overflow, bit12 eret.
REQ-010 mem_pc_i  in  32  MEM-stage instruction address; 0 means bubble.
REQ-011 mem_dslot_i  in  1  MEM instruction is in a delay slot.
REQ-012 status_i / cause_i / epc_i  in  32 each  current CP0 register values.
REQ-013 wb_cp0_we_i, wb_cp0_waddr_i[4:0], wb_cp0_wdata_i[31:0]  in  WB-stage CP0 write, used for bypass.
REQ-014 stallreq_id_i, stallreq_ex_i, stallreq_mem_i  in  1 each  stage stall requests.
REQ-015 excepttype_o  out  32  exception code to CP0.
REQ-016 pc_o  out  32  current MEM PC to CP0 (equals mem_pc_i).
REQ-017 dslot_o  out  1  delay-slot flag to CP0 (equals mem_dslot_i).
REQ-018 int_o  out  6  synchronized interrupt lines to CP0 cause IP.
REQ-019 flush_o  out  1  pipeline flush.
REQ-020 new_pc_o  out  32  redirect target, valid while flush_o=1.
REQ-021 stall_o  out  6  per-stage stall vector, bit0 = PC.

Function
REQ-022 States are IDLE and HOLD; an exception is accepted only in IDLE with mem_pc_i != 0.
REQ-023 Effective status/cause/epc are the WB bypass value when wb_cp0_we_i=1 and the address matches (status 12, cause 13, epc 14); otherwise the *_i value.
REQ-024 Interrupt pending = status.IE(bit0)=1, status.EXL(bit1)=0, and (cause[15:8] with IP[7:2] replaced by int_o) & status[15:8] != 0.
REQ-025 Priority, highest first: interrupt 32'h1, syscall 32'h8, RI 32'ha, trap 32'hd, overflow 32'hc, eret 32'he; exactly one code is issued.
REQ-026 On acceptance, in the same cycle (combinational): excepttype_o=code; flush_o=1; new_pc_o=effective epc for eret, EXC_VECTOR otherwise; stall_o=0.
REQ-027 On the next edge after acceptance, state becomes HOLD and the hold counter loads HOLD_CYCLES-1.
REQ-028 In HOLD: excepttype_o=0, flush_o=0, no acceptance, and the counter decrements; at counter 0, the next edge returns to IDLE.
REQ-029 Interrupts pending during HOLD or a bubble are deferred, not dropped, and are taken at the first eligible IDLE cycle if still pending.
REQ-030 With no accepted exception, excepttype_o=0 and new_pc_o=0.
REQ-031 stall_o: stallreq_mem -> 6'b011111; else stallreq_ex -> 6'b001111; else stallreq_id -> 6'b000111; else 0.
REQ-032 An accepted exception overrides any stall request in the same cycle.
REQ-033 int_o = SYNC_STAGES-flop synchronized int_i, with bit5 ORed with timer_int_i after synchronization.

Reset
REQ-034 Reset forces state to IDLE and clears the hold counter and all synchronizer flops, from any state including mid-HOLD.
REQ-035 Outputs during and immediately after reset: excepttype_o=0, flush_o=0, new_pc_o=0, stall_o=0, int_o=0.

Structure
REQ-036 The exception codes, CP0 register addresses and status/cause bit positions shall live in the shared defines package; no local literals shall be used.
REQ-037 The int_i synchronizer shall be one sub-module, int_sync, parameterized by width and depth.
REQ-038 The priority encoder and stall arbiter shall be combinational logic inside exc_ctrl.

Verification
REQ-039 Syscall: mem_exc_i bit8, mem_pc_i=32'h100 -> excepttype_o=32'h8, flush_o=1, new_pc_o=32'h40 that cycle, then 2 cycles with flush_o=0.
REQ-040 ERET with WB writing epc=32'h200 in the same cycle (cp0 epc_i=32'h300) -> new_pc_o=32'h200, excepttype_o=32'he.
REQ-041 Interrupt: status=32'h0000_0401, int_i[0] raised -> excepttype_o=32'h1 exactly SYNC_STAGES+1 cycles later (first valid PC); with status.EXL=1 -> no exception.
REQ-042 Overflow and interrupt in the same cycle -> 32'h1 only; overflow while in HOLD -> ignored.
REQ-043 stallreq_ex and stallreq_mem together -> stall_o=6'b011111; adding syscall in the same cycle -> stall_o=0, flush_o=1.
REQ-044 rst asserted during HOLD -> IDLE next cycle, and a syscall is accepted immediately after reset deasserts.
